// File: rtl/vga_text_update_ctrl.sv
// vga_text_update_ctrl: writes one channel row "CHnn: d.dddV" into the text char RAM, only during vblank.
// Define VGA_TEXT_CLEAR_EN to fill the whole table with spaces after reset.
module vga_text_update_ctrl #(
    parameter int COLS      = 12,
    parameter int ROWS      = 13,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        upd_req,
    input  logic [3:0]  upd_ch,
    input  logic [11:0] upd_mv,
    output logic        upd_ack,
    output logic        upd_err,
    output logic        busy,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data
);
    localparam logic [3:0] MAX_CH   = 4'(ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [7:0] COLS_W   = 8'(COLS);
    localparam logic [7:0] BASE_W   = 8'(BASE_ADDR);
`ifdef VGA_TEXT_CLEAR_EN
    localparam logic [7:0] LAST_CLR = 8'(COLS * ROWS - 1);
`endif

    typedef enum logic [2:0] {IDLE, CONV, WAIT_BLK, WRITE, ACK, CLEAR} state_t;

    state_t      state_q;
    logic [3:0]  ch_q, col_q, ch_tens, ch_units;
    logic [7:0]  cnt_q, chr_d, row_base;
    logic [11:0] bin_q;
    logic [15:0] bcd_q, bcd_d;

    // double-dabble: add 3 to every BCD digit >= 5 before each shift
    always_comb begin
        for (int i = 0; i < 4; i++)
            bcd_d[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end

    assign ch_tens  = (ch_q >= 4'd10) ? 4'd1 : 4'd0;
    assign ch_units = (ch_q >= 4'd10) ? ch_q - 4'd10 : ch_q;
    assign row_base = BASE_W + {4'd0, ch_q} * COLS_W;

    always_comb begin
        chr_d = 8'h56;
        case (col_q)
            4'd0:    chr_d = 8'h43;
            4'd1:    chr_d = 8'h48;
            4'd2:    chr_d = {4'h3, ch_tens};
            4'd3:    chr_d = {4'h3, ch_units};
            4'd4:    chr_d = 8'h3A;
            4'd5:    chr_d = 8'h20;
            4'd6:    chr_d = {4'h3, bcd_q[15:12]};
            4'd7:    chr_d = 8'h2E;
            4'd8:    chr_d = {4'h3, bcd_q[11:8]};
            4'd9:    chr_d = {4'h3, bcd_q[7:4]};
            4'd10:   chr_d = {4'h3, bcd_q[3:0]};
            default: chr_d = 8'h56;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef VGA_TEXT_CLEAR_EN
            state_q <= CLEAR;
`else
            state_q <= IDLE;
`endif
            ch_q    <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            upd_ack <= 1'b0;
            upd_err <= 1'b0;
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= 1'b0;
            upd_ack <= 1'b0;
            upd_err <= 1'b0;
            case (state_q)
                IDLE: if (upd_req) begin
                    if (upd_ch > MAX_CH) begin
                        upd_ack <= 1'b1;
                        upd_err <= 1'b1;
                    end else begin
                        ch_q    <= upd_ch;
                        bin_q   <= upd_mv;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= {bcd_d, bin_q} << 1;
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == 8'd11) state_q <= WAIT_BLK;
                end
                WAIT_BLK: if (vblnk_in) begin
                    col_q   <= '0;
                    state_q <= WRITE;
                end
                WRITE: if (vblnk_in) begin
                    wr_en   <= 1'b1;
                    wr_addr <= row_base + {4'd0, col_q};
                    wr_data <= chr_d;
                    col_q   <= col_q + 4'd1;
                    if (col_q == LAST_COL) state_q <= ACK;
                end
                ACK: begin
                    upd_ack <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
`ifdef VGA_TEXT_CLEAR_EN
                CLEAR: begin
                    busy <= 1'b1;
                    if (vblnk_in) begin
                        wr_en   <= 1'b1;
                        wr_addr <= BASE_W + cnt_q;
                        wr_data <= 8'h20;
                        cnt_q   <= cnt_q + 8'd1;
                        if (cnt_q == LAST_CLR) begin
                            busy    <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_text_update_ctrl.sv
// tb_vga_text_update_ctrl: scoreboard bench; stimulus queues expected RAM writes and acks,
// a negedge monitor pops and compares whenever the DUT writes or acks.
`timescale 1ns/1ps
module tb_vga_text_update_ctrl;
    logic        clk = 1'b0, rst = 1'b1, vblnk_in = 1'b1, upd_req = 1'b0;
    logic [3:0]  upd_ch = '0;
    logic [11:0] upd_mv = '0;
    logic        upd_ack, upd_err, busy, wr_en;
    logic [7:0]  wr_addr, wr_data;

    typedef struct {
        bit err;
        int at;
    } ack_t;

    int          cyc = 0, npass = 0, ntot = 0, wr_seen = 0;
    logic [15:0] wq[$];
    ack_t        aq[$];
    int          wcyc[$];

`ifdef VGA_TEXT_CLEAR_EN
    localparam bit TIMED = 1'b0;
`else
    localparam bit TIMED = 1'b1;
`endif

    vga_text_update_ctrl dut (
        .clk(clk), .rst(rst), .vblnk_in(vblnk_in), .upd_req(upd_req),
        .upd_ch(upd_ch), .upd_mv(upd_mv), .upd_ack(upd_ack), .upd_err(upd_err),
        .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    always @(negedge clk) begin : monitor
        logic [15:0] e;
        ack_t        a;
        if (!rst && wr_en) begin
            wr_seen++;
            wcyc.push_back(cyc);
            if (wq.size() == 0) check("unexpected_wr", int'(wr_addr), -1);
            else begin
                e = wq.pop_front();
                check("wr_addr", int'(wr_addr), int'(e[15:8]));
                check("wr_data", int'(wr_data), int'(e[7:0]));
            end
        end
        if (!rst && (upd_ack || upd_err)) begin
            if (aq.size() == 0) check("unexpected_ack", int'({upd_ack, upd_err}), -1);
            else begin
                a = aq.pop_front();
                check("ack", int'(upd_ack), 1);
                check("err", int'(upd_err), int'(a.err));
                if (a.at >= 0) check("ack_cycle", cyc, a.at);
            end
        end
    end

    task automatic wait_ack;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!upd_ack && n < 3000);
        if (!upd_ack) check("ack_timeout", 0, 1);
        upd_req = 1'b0;
    endtask

    task automatic wait_wr(input int target);
        int n = 0;
        while (wr_seen < target && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (wr_seen < target) check("wr_timeout", wr_seen, target);
    endtask

    task automatic send(input logic [3:0] ch, input logic [11:0] mv, input string txt,
                        input int base, input bit timed, output int k);
        ack_t a;
        @(negedge clk);
        for (int i = 0; i < 12; i++) wq.push_back({8'(base + i), txt[i]});
        k = cyc;
        a.err = 1'b0;
        a.at  = timed ? k + 27 : -1;
        aq.push_back(a);
        upd_ch  = ch;
        upd_mv  = mv;
        upd_req = 1'b1;
        wait_ack();
    endtask

    task automatic send_bad(input logic [3:0] ch);
        ack_t a;
        @(negedge clk);
        a.err = 1'b1;
        a.at  = cyc + 1;
        aq.push_back(a);
        upd_ch  = ch;
        upd_req = 1'b1;
        wait_ack();
        check("bad_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bad_busy_after", int'(busy), 0);
        end
    endtask

    task automatic release_rst;
        @(negedge clk);
        rst = 1'b0;
`ifdef VGA_TEXT_CLEAR_EN
        for (int i = 0; i < 156; i++) wq.push_back({8'(i), 8'h20});
`endif
    endtask

    initial begin
        int    w0, pw, k;
        string txt5;
        txt5 = "CH05: 0.321V";
        repeat (2) @(negedge clk);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(upd_ack), 0);
        check("rst_err", int'(upd_err), 0);
        check("rst_addr", int'(wr_addr), 0);
        release_rst();
`ifdef VGA_TEXT_CLEAR_EN
        send(4'd2, 12'd7, "CH02: 0.007V", 24, 1'b0, k);
`endif
        wcyc.delete();
        send(4'd3, 12'd1234, "CH03: 1.234V", 36, 1'b1, k);
        check("first_wr_cycle", wcyc.size() > 0 ? wcyc[0] : -1, k + 15);
        check("row_wr_count", wcyc.size(), 12);
        send(4'd12, 12'd4095, "CH12: 4.095V", 144, 1'b1, k);
        send(4'd0, 12'd0, "CH00: 0.000V", 0, 1'b1, k);

        // request while not blanking: must sit in WAIT_BLK with no writes
        vblnk_in = 1'b0;
        w0 = wr_seen;
        fork
            send(4'd7, 12'd9, "CH07: 0.009V", 84, 1'b0, k);
            begin
                repeat (30) @(negedge clk);
                check("noblank_wr_count", wr_seen - w0, 0);
                check("noblank_busy", int'(busy), 1);
                vblnk_in = 1'b1;
            end
        join

        send_bad(4'd13);
        send_bad(4'd15);

        // blank drops after 5 writes: pause, then resume at the next column
        w0 = wr_seen;
        fork
            send(4'd3, 12'd1234, "CH03: 1.234V", 36, 1'b0, k);
            begin
                wait_wr(w0 + 5);
                vblnk_in = 1'b0;
                pw = 0;
                repeat (8) begin
                    @(negedge clk);
                    if (wr_en) pw++;
                end
                check("pause_wr_count", pw, 0);
                check("pause_wr_seen", wr_seen - w0, 5);
                vblnk_in = 1'b1;
            end
        join

        // async reset in the middle of a row
        w0 = wr_seen;
        @(negedge clk);
        for (int i = 0; i < 12; i++) wq.push_back({8'(60 + i), txt5[i]});
        upd_ch  = 4'd5;
        upd_mv  = 12'd321;
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        wait_wr(w0 + 4);
        #2 rst = 1'b1;
        #1;
        check("arst_wr_en", int'(wr_en), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_addr", int'(wr_addr), 0);
        check("arst_data", int'(wr_data), 0);
        check("arst_ack", int'(upd_ack | upd_err), 0);
        wq.delete();
        aq.delete();
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_wr_en", int'(wr_en), 0);
        end
        release_rst();
`ifndef VGA_TEXT_CLEAR_EN
        @(negedge clk);
        check("post_rst_idle", int'(busy), 0);
`endif
        send(4'd1, 12'd500, "CH01: 0.500V", 12, TIMED, k);

        repeat (5) @(negedge clk);
        check("wq_empty", wq.size(), 0);
        check("aq_empty", aq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
